// File: rtl/multi_port_scoreboard.sv
// Multi-port in-order scoreboard: allocates ring entries in order, collects
// out-of-order writebacks and retires completed entries in order.
module multi_port_scoreboard #(
    parameter int unsigned NR_ENTRIES = 8,
    parameter int unsigned ISSUE_W    = 2,
    parameter int unsigned WB_W       = 4,
    parameter int unsigned COMMIT_W   = 2,
    parameter int unsigned PAYLOAD_W  = 32,
    parameter int unsigned DATA_W     = 64,
    localparam int unsigned ID_W      = $clog2(NR_ENTRIES),
    localparam int unsigned CNT_W     = ID_W + 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flush_i,
    input  logic [ISSUE_W-1:0]                  in_valid_i,
    input  logic [ISSUE_W-1:0][PAYLOAD_W-1:0]   in_payload_i,
    output logic [ISSUE_W-1:0]                  in_ready_o,
    output logic [ISSUE_W-1:0][ID_W-1:0]        in_trans_id_o,
    input  logic [WB_W-1:0]                     wb_valid_i,
    input  logic [WB_W-1:0][ID_W-1:0]           wb_trans_id_i,
    input  logic [WB_W-1:0][DATA_W-1:0]         wb_data_i,
    output logic [COMMIT_W-1:0]                 commit_valid_o,
    output logic [COMMIT_W-1:0][PAYLOAD_W-1:0]  commit_payload_o,
    output logic [COMMIT_W-1:0][DATA_W-1:0]     commit_data_o,
    input  logic [COMMIT_W-1:0]                 commit_ack_i,
    output logic [CNT_W-1:0]                    count_o,
    output logic                                full_o,
    output logic                                empty_o
);

    logic [ID_W-1:0]       head_q;
    logic [ID_W-1:0]       tail_q;
    logic [CNT_W-1:0]      count_q;
    logic [NR_ENTRIES-1:0] valid_q;
    logic [NR_ENTRIES-1:0] done_q;
    logic [PAYLOAD_W-1:0]  payload_q [NR_ENTRIES];
    logic [DATA_W-1:0]     data_q    [NR_ENTRIES];

    logic [ISSUE_W-1:0]    accept;
    logic [CNT_W-1:0]      n_acc;
    logic [WB_W-1:0]       wb_hit;
    logic [COMMIT_W-1:0]   commit_fire;
    logic [CNT_W-1:0]      n_com;
    logic [CNT_W-1:0]      free_slots;

    // Status outputs straight from the registered occupancy
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(NR_ENTRIES));
    assign empty_o = (count_q == '0);

    // Per-port readiness and IDs; frees from this cycle's commits are not counted
    always_comb begin
        free_slots = CNT_W'(NR_ENTRIES) - count_q;
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            in_ready_o[k]    = (free_slots > CNT_W'(k));
            in_trans_id_o[k] = tail_q + ID_W'(k);
        end
    end

    // In-order allocation: only the leading run of valid & ready ports is taken
    always_comb begin
        logic ok;
        ok     = ~rst_i & ~flush_i;
        n_acc  = '0;
        accept = '0;
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            ok        = ok & in_valid_i[k] & in_ready_o[k];
            accept[k] = ok;
            if (ok) begin
                n_acc = n_acc + CNT_W'(1);
            end
        end
    end

    // Writebacks only land on entries that are currently allocated
    always_comb begin
        wb_hit = '0;
        for (int unsigned j = 0; j < WB_W; j++) begin
            wb_hit[j] = wb_valid_i[j] & valid_q[wb_trans_id_i[j]] & ~rst_i & ~flush_i;
        end
    end

    // Commit window: leading run of valid & done entries starting at head
    always_comb begin
        logic            ok;
        logic [ID_W-1:0] idx;
        ok               = 1'b1;
        idx              = '0;
        commit_valid_o   = '0;
        commit_payload_o = '0;
        commit_data_o    = '0;
        for (int unsigned k = 0; k < COMMIT_W; k++) begin
            idx                 = head_q + ID_W'(k);
            ok                  = ok & valid_q[idx] & done_q[idx];
            commit_valid_o[k]   = ok;
            commit_payload_o[k] = payload_q[idx];
            commit_data_o[k]    = data_q[idx];
        end
    end

    // Number of retiring entries: leading ones of ack & valid
    always_comb begin
        logic ok;
        ok          = 1'b1;
        n_com       = '0;
        commit_fire = '0;
        for (int unsigned k = 0; k < COMMIT_W; k++) begin
            ok             = ok & commit_ack_i[k] & commit_valid_o[k];
            commit_fire[k] = ok;
            if (ok) begin
                n_com = n_com + CNT_W'(1);
            end
        end
    end

    // Control state: pointers, occupancy and per-entry valid/done flags
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            // Later ports overwrite earlier ones, so the highest port wins
            for (int unsigned j = 0; j < WB_W; j++) begin
                if (wb_hit[j]) begin
                    done_q[wb_trans_id_i[j]] <= 1'b1;
                end
            end
            for (int unsigned k = 0; k < COMMIT_W; k++) begin
                if (commit_fire[k]) begin
                    valid_q[head_q + ID_W'(k)] <= 1'b0;
                    done_q[head_q + ID_W'(k)]  <= 1'b0;
                end
            end
            for (int unsigned k = 0; k < ISSUE_W; k++) begin
                if (accept[k]) begin
                    valid_q[tail_q + ID_W'(k)] <= 1'b1;
                    done_q[tail_q + ID_W'(k)]  <= 1'b0;
                end
            end
            head_q  <= head_q + ID_W'(n_com);
            tail_q  <= tail_q + ID_W'(n_acc);
            count_q <= count_q + n_acc - n_com;
        end
    end

    // Payload and result storage; contents are qualified by valid/done
    always_ff @(posedge clk_i) begin
        for (int unsigned j = 0; j < WB_W; j++) begin
            if (wb_hit[j]) begin
                data_q[wb_trans_id_i[j]] <= wb_data_i[j];
            end
        end
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            if (accept[k]) begin
                payload_q[tail_q + ID_W'(k)] <= in_payload_i[k];
            end
        end
    end

endmodule

// File: tb/tb_multi_port_scoreboard.sv
// Bench for multi_port_scoreboard: directed scenarios plus random traffic
// checked against an in-order queue model.
module tb_multi_port_scoreboard;

    logic              clk_i;
    logic              rst_i;
    logic              flush_i;
    logic [1:0]        in_valid_i;
    logic [1:0][31:0]  in_payload_i;
    logic [1:0]        in_ready_o;
    logic [1:0][2:0]   in_trans_id_o;
    logic [1:0]        wb_valid_i;
    logic [1:0][2:0]   wb_trans_id_i;
    logic [1:0][63:0]  wb_data_i;
    logic [1:0]        commit_valid_o;
    logic [1:0][31:0]  commit_payload_o;
    logic [1:0][63:0]  commit_data_o;
    logic [1:0]        commit_ack_i;
    logic [3:0]        count_o;
    logic              full_o;
    logic              empty_o;

    multi_port_scoreboard #(
        .NR_ENTRIES(8), .ISSUE_W(2), .WB_W(2), .COMMIT_W(2),
        .PAYLOAD_W(32), .DATA_W(64)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_payload_i(in_payload_i),
        .in_ready_o(in_ready_o), .in_trans_id_o(in_trans_id_o),
        .wb_valid_i(wb_valid_i), .wb_trans_id_i(wb_trans_id_i), .wb_data_i(wb_data_i),
        .commit_valid_o(commit_valid_o), .commit_payload_o(commit_payload_o),
        .commit_data_o(commit_data_o), .commit_ack_i(commit_ack_i),
        .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: in-flight entries in program order
    typedef struct {
        logic [31:0] payload;
        logic        done;
        logic [63:0] data;
        int unsigned id;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_tail = 0;

    logic [1:0]       exp_ready;
    logic [1:0]       exp_cv;
    logic [3:0]       exp_count;
    logic [1:0][2:0]  exp_id;
    logic [1:0][31:0] exp_cp;
    logic [1:0][63:0] exp_cd;

    function automatic void model_expect();
        bit ok;
        exp_count = 4'(mq.size());
        ok = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_ready[k] = ((8 - mq.size()) > k);
            exp_id[k]    = 3'((m_tail + k) % 8);
            if (ok && k < mq.size() && mq[k].done) begin
                exp_cv[k] = 1'b1;
                exp_cp[k] = mq[k].payload;
                exp_cd[k] = mq[k].data;
            end else begin
                ok        = 1'b0;
                exp_cv[k] = 1'b0;
                exp_cp[k] = '0;
                exp_cd[k] = '0;
            end
        end
    endfunction

    function automatic void model_update();
        int n;
        bit ok;
        ent_t e;
        if (rst_i || flush_i) begin
            mq.delete();
            m_tail = 0;
            return;
        end
        model_expect();
        for (int j = 0; j < 2; j++) begin
            if (wb_valid_i[j]) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i].id == int'(wb_trans_id_i[j])) begin
                        e = mq[i];
                        e.done = 1'b1;
                        e.data = wb_data_i[j];
                        mq[i] = e;
                    end
                end
            end
        end
        n = 0;
        for (int k = 0; k < 2; k++) begin
            if (n == k && exp_cv[k] && commit_ack_i[k]) n++;
        end
        for (int k = 0; k < n; k++) void'(mq.pop_front());
        ok = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ok = ok && in_valid_i[k] && exp_ready[k];
            if (ok) begin
                e.payload = in_payload_i[k];
                e.done    = 1'b0;
                e.data    = '0;
                e.id      = m_tail;
                mq.push_back(e);
                m_tail = (m_tail + 1) % 8;
            end
        end
    endfunction

    task automatic idle();
        rst_i        = 1'b0;
        flush_i      = 1'b0;
        in_valid_i   = '0;
        wb_valid_i   = '0;
        commit_ack_i = '0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b1; in_valid_i = 2'b11;
        wb_valid_i = 2'b11; commit_ack_i = 2'b11;
        tick(); idle();
        n_checks++;
        if ({count_o, full_o, empty_o, in_ready_o, commit_valid_o} !== {4'd0, 1'b0, 1'b1, 2'b11, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_status: got %h expected %h",
                     {count_o, full_o, empty_o, in_ready_o, commit_valid_o}, {4'd0, 1'b0, 1'b1, 2'b11, 2'b00});
        end
        n_checks++;
        if ({in_trans_id_o[1], in_trans_id_o[0]} !== {3'd1, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_ids: got %h expected %h", {in_trans_id_o[1], in_trans_id_o[0]}, {3'd1, 3'd0});
        end
    endtask

    task automatic test_basic();
        in_valid_i = 2'b11; in_payload_i[0] = 32'hA0; in_payload_i[1] = 32'hA1;
        n_checks++;
        if ({in_ready_o, in_trans_id_o[1], in_trans_id_o[0]} !== {2'b11, 3'd1, 3'd0}) begin
            n_fail++;
            $display("FAIL basic_alloc_ids: got %h expected %h",
                     {in_ready_o, in_trans_id_o[1], in_trans_id_o[0]}, {2'b11, 3'd1, 3'd0});
        end
        tick(); idle();
        n_checks++;
        if ({count_o, commit_valid_o} !== {4'd2, 2'b00}) begin
            n_fail++;
            $display("FAIL basic_count: got %h expected %h", {count_o, commit_valid_o}, {4'd2, 2'b00});
        end
        wb_valid_i = 2'b01; wb_trans_id_i[0] = 3'd1; wb_data_i[0] = 64'h11;
        tick(); idle();
        n_checks++;
        if (commit_valid_o !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_wb_young: got %b expected 00", commit_valid_o);
        end
        wb_valid_i = 2'b01; wb_trans_id_i[0] = 3'd0; wb_data_i[0] = 64'h10;
        tick(); idle();
        n_checks++;
        if ({commit_valid_o, commit_payload_o, commit_data_o} !== {2'b11, 32'hA1, 32'hA0, 64'h11, 64'h10}) begin
            n_fail++;
            $display("FAIL basic_commit: got %h expected %h",
                     {commit_valid_o, commit_payload_o, commit_data_o}, {2'b11, 32'hA1, 32'hA0, 64'h11, 64'h10});
        end
        commit_ack_i = 2'b11;
        tick(); idle();
        n_checks++;
        if ({count_o, empty_o, commit_valid_o} !== {4'd0, 1'b1, 2'b00}) begin
            n_fail++;
            $display("FAIL basic_drain: got %h expected %h", {count_o, empty_o, commit_valid_o}, {4'd0, 1'b1, 2'b00});
        end
    endtask

    task automatic test_non_prefix();
        in_valid_i = 2'b10; in_payload_i[1] = 32'hBAD;
        tick(); idle();
        n_checks++;
        if ({count_o, in_trans_id_o[0]} !== {4'd0, 3'd2}) begin
            n_fail++;
            $display("FAIL non_prefix: got %h expected %h", {count_o, in_trans_id_o[0]}, {4'd0, 3'd2});
        end
    endtask

    task automatic test_full();
        for (int c = 0; c < 4; c++) begin
            in_valid_i = 2'b11;
            in_payload_i[0] = 32'(200 + 2 * c); in_payload_i[1] = 32'(201 + 2 * c);
            tick();
        end
        idle();
        n_checks++;
        if ({full_o, in_ready_o, count_o} !== {1'b1, 2'b00, 4'd8}) begin
            n_fail++;
            $display("FAIL full_status: got %h expected %h", {full_o, in_ready_o, count_o}, {1'b1, 2'b00, 4'd8});
        end
        wb_valid_i = 2'b11; wb_trans_id_i[0] = 3'd2; wb_trans_id_i[1] = 3'd3;
        wb_data_i[0] = 64'h22; wb_data_i[1] = 64'h33;
        tick(); idle();
        commit_ack_i = 2'b11; in_valid_i = 2'b11;
        n_checks++;
        if ({commit_valid_o, in_ready_o} !== {2'b11, 2'b00}) begin
            n_fail++;
            $display("FAIL full_commit_ready: got %h expected %h", {commit_valid_o, in_ready_o}, {2'b11, 2'b00});
        end
        tick(); idle();
        n_checks++;
        if ({count_o, in_ready_o, full_o, in_trans_id_o[0]} !== {4'd6, 2'b11, 1'b0, 3'd2}) begin
            n_fail++;
            $display("FAIL full_after_commit: got %h expected %h",
                     {count_o, in_ready_o, full_o, in_trans_id_o[0]}, {4'd6, 2'b11, 1'b0, 3'd2});
        end
    endtask

    task automatic test_wrap();
        rst_i = 1'b1; tick(); idle();
        for (int c = 0; c < 3; c++) begin
            in_valid_i = 2'b11; tick();
        end
        idle();
        for (int c = 0; c < 3; c++) begin
            wb_valid_i = 2'b11; wb_trans_id_i[0] = 3'(2 * c); wb_trans_id_i[1] = 3'(2 * c + 1);
            tick();
        end
        idle();
        for (int c = 0; c < 3; c++) begin
            commit_ack_i = 2'b11; tick();
        end
        idle();
        n_checks++;
        if ({empty_o, in_trans_id_o[0]} !== {1'b1, 3'd6}) begin
            n_fail++;
            $display("FAIL wrap_setup: got %h expected %h", {empty_o, in_trans_id_o[0]}, {1'b1, 3'd6});
        end
        in_valid_i = 2'b11; in_payload_i[0] = 32'h106; in_payload_i[1] = 32'h107;
        n_checks++;
        if ({in_trans_id_o[1], in_trans_id_o[0]} !== {3'd7, 3'd6}) begin
            n_fail++;
            $display("FAIL wrap_ids_a: got %h expected %h", {in_trans_id_o[1], in_trans_id_o[0]}, {3'd7, 3'd6});
        end
        tick();
        in_payload_i[0] = 32'h100; in_payload_i[1] = 32'h101;
        n_checks++;
        if ({in_trans_id_o[1], in_trans_id_o[0]} !== {3'd1, 3'd0}) begin
            n_fail++;
            $display("FAIL wrap_ids_b: got %h expected %h", {in_trans_id_o[1], in_trans_id_o[0]}, {3'd1, 3'd0});
        end
        tick(); idle();
        wb_valid_i = 2'b11; wb_trans_id_i[0] = 3'd6; wb_trans_id_i[1] = 3'd7;
        tick();
        wb_trans_id_i[0] = 3'd0; wb_trans_id_i[1] = 3'd1;
        tick(); idle();
        commit_ack_i = 2'b11;
        n_checks++;
        if ({commit_valid_o, commit_payload_o} !== {2'b11, 32'h107, 32'h106}) begin
            n_fail++;
            $display("FAIL wrap_commit_a: got %h expected %h", {commit_valid_o, commit_payload_o}, {2'b11, 32'h107, 32'h106});
        end
        tick();
        n_checks++;
        if ({commit_valid_o, commit_payload_o} !== {2'b11, 32'h101, 32'h100}) begin
            n_fail++;
            $display("FAIL wrap_commit_b: got %h expected %h", {commit_valid_o, commit_payload_o}, {2'b11, 32'h101, 32'h100});
        end
        tick(); idle();
        n_checks++;
        if ({empty_o, count_o, in_trans_id_o[0]} !== {1'b1, 4'd0, 3'd2}) begin
            n_fail++;
            $display("FAIL wrap_empty: got %h expected %h", {empty_o, count_o, in_trans_id_o[0]}, {1'b1, 4'd0, 3'd2});
        end
    endtask

    task automatic test_wb_collision();
        in_valid_i = 2'b11; in_payload_i[0] = 32'h302; in_payload_i[1] = 32'h303;
        tick(); idle();
        wb_valid_i = 2'b11; wb_trans_id_i[0] = 3'd3; wb_trans_id_i[1] = 3'd3;
        wb_data_i[0] = 64'hA; wb_data_i[1] = 64'hB;
        tick(); idle();
        wb_valid_i = 2'b11; wb_trans_id_i[0] = 3'd5; wb_trans_id_i[1] = 3'd5;
        wb_data_i[0] = 64'hDEAD; wb_data_i[1] = 64'hBEEF;
        tick(); idle();
        n_checks++;
        if ({count_o, commit_valid_o} !== {4'd2, 2'b00}) begin
            n_fail++;
            $display("FAIL wb_unalloc: got %h expected %h", {count_o, commit_valid_o}, {4'd2, 2'b00});
        end
        wb_valid_i = 2'b01; wb_trans_id_i[0] = 3'd2; wb_data_i[0] = 64'h2;
        tick(); idle();
        n_checks++;
        if ({commit_valid_o, commit_data_o} !== {2'b11, 64'hB, 64'h2}) begin
            n_fail++;
            $display("FAIL wb_collision: got %h expected %h", {commit_valid_o, commit_data_o}, {2'b11, 64'hB, 64'h2});
        end
        commit_ack_i = 2'b11;
        tick(); idle();
    endtask

    task automatic test_flush();
        in_valid_i = 2'b11; tick(); tick();
        in_valid_i = 2'b01; tick(); idle();
        wb_valid_i = 2'b11; wb_trans_id_i[0] = 3'd4; wb_trans_id_i[1] = 3'd5;
        tick(); idle();
        n_checks++;
        if ({count_o, commit_valid_o} !== {4'd5, 2'b11}) begin
            n_fail++;
            $display("FAIL flush_setup: got %h expected %h", {count_o, commit_valid_o}, {4'd5, 2'b11});
        end
        flush_i = 1'b1; in_valid_i = 2'b11; commit_ack_i = 2'b11;
        wb_valid_i = 2'b11; wb_trans_id_i[0] = 3'd6; wb_trans_id_i[1] = 3'd7;
        tick(); idle();
        n_checks++;
        if ({count_o, commit_valid_o, empty_o, in_trans_id_o[0]} !== {4'd0, 2'b00, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL flush_result: got %h expected %h",
                     {count_o, commit_valid_o, empty_o, in_trans_id_o[0]}, {4'd0, 2'b00, 1'b1, 3'd0});
        end
        in_valid_i = 2'b11; tick(); idle();
        n_checks++;
        if ({count_o, in_trans_id_o[0]} !== {4'd2, 3'd2}) begin
            n_fail++;
            $display("FAIL flush_realloc: got %h expected %h", {count_o, in_trans_id_o[0]}, {4'd2, 3'd2});
        end
    endtask

    task automatic test_reset_mid();
        wb_valid_i = 2'b11; wb_trans_id_i[0] = 3'd0; wb_trans_id_i[1] = 3'd1;
        tick(); idle();
        rst_i = 1'b1; flush_i = 1'b1; commit_ack_i = 2'b11; in_valid_i = 2'b11;
        tick(); idle();
        n_checks++;
        if ({count_o, commit_valid_o, empty_o, in_ready_o, in_trans_id_o[0]} !== {4'd0, 2'b00, 1'b1, 2'b11, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_mid: got %h expected %h",
                     {count_o, commit_valid_o, empty_o, in_ready_o, in_trans_id_o[0]}, {4'd0, 2'b00, 1'b1, 2'b11, 3'd0});
        end
    endtask

    task automatic test_random();
        rst_i = 1'b1; tick(); idle();
        for (int c = 0; c < 3000; c++) begin
            rst_i        = ($urandom_range(0, 499) == 0);
            flush_i      = ($urandom_range(0, 99) == 0);
            in_valid_i   = 2'($urandom);
            commit_ack_i = 2'($urandom);
            for (int k = 0; k < 2; k++) begin
                in_payload_i[k]  = $urandom;
                wb_valid_i[k]    = ($urandom_range(0, 2) != 0);
                wb_data_i[k]     = {$urandom, $urandom};
                if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                    wb_trans_id_i[k] = 3'(mq[$urandom_range(0, mq.size() - 1)].id);
                else
                    wb_trans_id_i[k] = 3'($urandom);
            end
            model_expect();
            n_checks++;
            if ({in_ready_o, count_o, full_o, empty_o} !== {exp_ready, exp_count, exp_count == 4'd8, exp_count == 4'd0}) begin
                n_fail++;
                $display("FAIL rand_status cycle %0d: got %h expected %h", c,
                         {in_ready_o, count_o, full_o, empty_o}, {exp_ready, exp_count, exp_count == 4'd8, exp_count == 4'd0});
            end
            n_checks++;
            if (in_trans_id_o !== exp_id) begin
                n_fail++;
                $display("FAIL rand_ids cycle %0d: got %h expected %h", c, in_trans_id_o, exp_id);
            end
            n_checks++;
            if (commit_valid_o !== exp_cv) begin
                n_fail++;
                $display("FAIL rand_commit_valid cycle %0d: got %b expected %b", c, commit_valid_o, exp_cv);
            end
            for (int k = 0; k < 2; k++) begin
                if (exp_cv[k]) begin
                    n_checks++;
                    if ({commit_payload_o[k], commit_data_o[k]} !== {exp_cp[k], exp_cd[k]}) begin
                        n_fail++;
                        $display("FAIL rand_commit_port%0d cycle %0d: got %h expected %h", k, c,
                                 {commit_payload_o[k], commit_data_o[k]}, {exp_cp[k], exp_cd[k]});
                    end
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        in_payload_i  = '0;
        wb_trans_id_i = '0;
        wb_data_i     = '0;
        @(negedge clk_i);
        test_reset();
        test_basic();
        test_non_prefix();
        test_full();
        test_wrap();
        test_wb_collision();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_port_scoreboard.md
MULTI_PORT_SCOREBOARD -- requirements
Module: multi_port_scoreboard

Interface
REQ-001 SHALL have parameter NR_ENTRIES, default 8, ring depth (power of 2, >=4).
REQ-002 SHALL have parameter ISSUE_W, default 2, allocation ports per cycle (1..4, <=NR_ENTRIES).
REQ-003 SHALL have parameter WB_W, default 4, writeback ports.
REQ-004 SHALL have parameter COMMIT_W, default 2, commit ports (1..4, <=NR_ENTRIES).
REQ-005 SHALL have parameter PAYLOAD_W, default 32, opaque entry payload width.
REQ-006 SHALL have parameter DATA_W, default 64, result width; ID_W = clog2(NR_ENTRIES).
REQ-007 SHALL have clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-008 SHALL have rst_i  input  1  reset, synchronous, active-high.
REQ-009 SHALL have flush_i  input  1  discard all entries.
REQ-010 SHALL have in_valid_i  input  ISSUE_W  allocation request per port.
REQ-011 SHALL have in_payload_i  input  ISSUE_W x PAYLOAD_W  payload per port.
REQ-012 SHALL have in_ready_o  output  ISSUE_W  slot available per port.
REQ-013 SHALL have in_trans_id_o  output  ISSUE_W x ID_W  ID assigned per port.
REQ-014 SHALL have wb_valid_i  input  WB_W, wb_trans_id_i  input  WB_W x ID_W, wb_data_i  input  WB_W x DATA_W  results.
REQ-015 SHALL have commit_valid_o  output  COMMIT_W, commit_payload_o  output  COMMIT_W x PAYLOAD_W, commit_data_o  output  COMMIT_W x DATA_W, commit_ack_i  input  COMMIT_W.
REQ-016 SHALL have count_o  output  ID_W+1  occupied entries; full_o, empty_o  output  1 each.

Function
REQ-017 SHALL keep head, tail (ID_W bits, wrap mod NR_ENTRIES) and count registers; per entry valid, done, payload, data.
REQ-018 in_ready_o[k] SHALL be 1 iff (NR_ENTRIES - registered count) > k; slots freed this cycle are not reusable until next cycle.
REQ-019 in_trans_id_o[k] SHALL equal (tail + k) mod NR_ENTRIES, combinational.
REQ-020 Allocation SHALL be in order: port k accepted iff in_valid_i[k] & in_ready_o[k] and port k-1 accepted (k>0); non-prefix valid bits ignored.
REQ-021 Accepted entry SHALL be written valid=1, done=0 at the edge; tail advances by accepted count.
REQ-022 Writeback on port j SHALL set done=1 and data for entry wb_trans_id_i[j] only if that entry is valid (registered); otherwise ignored.
REQ-023 Multiple writebacks to one ID in a cycle SHALL resolve to the highest-numbered port.
REQ-024 commit_valid_o[k] SHALL be 1 iff entry (head+k) is valid and done (registered) and commit_valid_o[k-1] (k>0); payload/data from that entry.
REQ-025 Commit count SHALL be leading ones of (commit_ack_i & commit_valid_o); those entries are cleared, head advances by that count; ack on an invalid port is ignored.
REQ-026 count SHALL update as count + accepted - committed in the same cycle; full_o = (count==NR_ENTRIES), empty_o = (count==0), from registers.
REQ-027 Latency: allocate at edge t, writeback earliest in cycle t+1, commit_valid_o earliest in cycle after writeback edge; no same-cycle writeback-to-commit bypass.
REQ-028 flush_i SHALL clear all valid/done, head=tail=count=0, and override allocation, writeback and commit that cycle.
REQ-029 Wrap-around SHALL be seamless: IDs NR_ENTRIES-1 then 0 are consecutive for allocation and commit.

Reset
REQ-030 rst_i SHALL, at the next edge, set head=tail=count=0, all valid/done=0; outputs then in_ready_o=all ones, in_trans_id_o[k]=k, commit_valid_o=0, count_o=0, empty_o=1, full_o=0.
REQ-031 rst_i SHALL take priority over flush_i and all traffic; reset mid-operation discards all entries without commit.
REQ-032 Payload/data storage SHALL need no reset.

Verification (NR_ENTRIES=8, ISSUE_W=2, WB_W=2, COMMIT_W=2)
REQ-033 Reset, then in_valid_i=11 one cycle -> IDs 0,1 accepted, count_o=2; wb IDs 1 then 0 in successive cycles -> commit_valid_o=00 after first, 11 after second.
REQ-034 in_valid_i=10 (port0 invalid, port1 valid) -> nothing accepted, count unchanged, tail unchanged.
REQ-035 Fill 8 entries -> full_o=1, in_ready_o=00; same cycle commit 2 with in_valid_i=11 -> none accepted; next cycle in_ready_o=11.
REQ-036 Wrap: head=tail=6, allocate 4 -> IDs 6,7,0,1; wb all, ack all -> commits in order 6,7 then 0,1; empty_o=1.
REQ-037 Two wb ports both target ID 3 with data 0xA, 0xB -> commit_data_o shows 0xB; wb to unallocated ID 5 -> no state change.
REQ-038 flush_i with 5 entries, simultaneous alloc/wb/ack -> next cycle count_o=0, commit_valid_o=0, in_trans_id_o[0]=0.
